mul_sched: RTL

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_pkg.sv | 12 +
 rtl/mul_4.sv | 35 +++
 rtl/mul_sched.sv | 88 ++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared widths and FSM encoding for the multiplier scheduler
package mul_sched_pkg;
    localparam int NUM_REQ = 4;
    localparam int ID_W = 2;
    localparam int OP_W = 4;
    localparam int P_W = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/mul_4.sv
// mul_4: 4x4 unsigned array multiplier built from AND partial products and ripple full-adder rows
module mul_4
    import mul_sched_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic [P_W-1:0]  p
);
    logic [OP_W:0]   acc;
    logic [OP_W-1:0] x;
    logic [OP_W-1:0] y;
    logic            cy;

    // Each row adds the next partial product to the previous row shifted down; its LSB is final.
    always_comb begin
        acc = {1'b0, a & {OP_W{b[0]}}};
        x = '0;
        y = '0;
        cy = 1'b0;
        p = '0;
        p[0] = acc[0];
        for (int i = 1; i < OP_W; i++) begin
            x = acc[OP_W:1];
            y = a & {OP_W{b[i]}};
            cy = 1'b0;
            for (int j = 0; j < OP_W; j++) begin
                acc[j] = x[j] ^ y[j] ^ cy;
                cy = (x[j] & y[j]) | (cy & (x[j] ^ y[j]));
            end
            acc[OP_W] = cy;
            p[i] = acc[0];
        end
        p[P_W-1:OP_W-1] = acc;
    end
endmodule

// File: rtl/mul_sched.sv
// mul_sched: round-robin arbiter and IDLE/CALC/RESP FSM sharing one mul_4 among four requesters
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [4*NUM_REQ-1:0]  req_a,
    input  logic [4*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [P_W-1:0]        rsp_p,
    output logic                  busy,
    output logic [7:0]            op_cnt
);
    state_t          state;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] win;
    logic            found;
    logic [ID_W-1:0] op_id;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic [P_W-1:0]  prod;

    // Search starts just past the last granted requester and wraps around.
    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_grant + ID_W'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end

    assign req_ready = (state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
    assign busy = state != IDLE;

    mul_4 u_mul (
        .a(op_a),
        .b(op_b),
        .p(prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            op_a <= '0;
            op_b <= '0;
            op_id <= '0;
            rsp_p <= '0;
            rsp_id <= '0;
            rsp_valid <= 1'b0;
            op_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_a <= req_a[win*OP_W +: OP_W];
                    op_b <= req_b[win*OP_W +: OP_W];
                    op_id <= win;
                    last_grant <= win;
                    state <= CALC;
                end
                CALC: begin
                    rsp_p <= prod;
                    rsp_id <= op_id;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    op_cnt <= op_cnt + 8'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
